// File: rtl/dsm_run_ctrl.sv
// Run sequencer for the delta-sigma modulator test path: holds the datapath
// in reset, streams stimulus samples as offset-binary words, flushes with
// midscale, and captures the decimated CIC output into a small FWFT FIFO.
module dsm_run_ctrl #(
  parameter int WIDTH        = 16,
  parameter int CIC_WIDTH    = 26,
  parameter int ADDR_WIDTH   = 20,
  parameter int RST_CYCLES   = 5,
  parameter int FLUSH_CYCLES = 128,
  parameter int SETTLE       = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_len,
  output logic [ADDR_WIDTH-1:0]       stim_addr,
  input  logic [WIDTH-1:0]            stim_data,
  output logic                        mod_rstn,
  output logic                        mod_en,
  output logic [WIDTH-1:0]            mod_in,
  input  logic signed [CIC_WIDTH-1:0] cic_out,
  input  logic                        cic_ce,
  output logic [CIC_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  // One shared down-counter times RESET, RUN and FLUSH, so it must be wide
  // enough for the longest of the three.
  localparam int RS_W   = $clog2(RST_CYCLES + 1);
  localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);
  localparam int CNT_W0 = (RS_W > FL_W) ? RS_W : FL_W;
  localparam int CNT_W  = (CNT_W0 > ADDR_WIDTH) ? CNT_W0 : ADDR_WIDTH;
  localparam int DEC_W  = $clog2(SETTLE + 2);

  // Offset-binary zero: flipping the MSB maps two's complement onto it.
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_PRIME,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   len_q;

  logic [CIC_WIDTH-1:0]    fifo_mem [4];
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              count;
  logic [DEC_W-1:0]        dec_cnt;

  logic start_acc;
  logic in_window;
  logic settled;
  logic full;
  logic pop;
  logic push_req;
  logic push;

  assign start_acc = start && (state == S_IDLE);
  assign in_window = (state == S_RUN) || (state == S_FLUSH);
  assign settled   = (dec_cnt == DEC_W'(SETTLE));
  assign full      = (count == 3'd4);
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign push_req  = cic_ce && in_window && settled;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;

  // Run sequencer: state, timing counter and all registered datapath controls.
  // NOTE: every register here uses non-blocking assignment so that all
  // branches see the pre-edge values of state and cnt.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      stim_addr <= '0;
      mod_rstn  <= 1'b0;
      mod_en    <= 1'b0;
      mod_in    <= MIDSCALE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= cfg_len;
            cnt   <= CNT_W'(RST_CYCLES - 1);
            busy  <= 1'b1;
            state <= S_RESET;
          end
        end
        S_RESET: begin
          if (cnt == '0) begin
            mod_rstn <= 1'b1;
            state    <= S_PRIME;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_PRIME: begin
          // Address 0 was presented during PRIME, so RUN starts fetching at 1
          // to keep the read pipeline one sample ahead.
          if (len_q != '0) begin
            cnt       <= CNT_W'(len_q) - CNT_W'(1);
            stim_addr <= (len_q > ADDR_WIDTH'(1)) ? ADDR_WIDTH'(1) : '0;
            state     <= S_RUN;
          end else begin
            cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            state <= S_FLUSH;
          end
        end
        S_RUN: begin
          mod_in <= stim_data ^ MIDSCALE;
          mod_en <= 1'b1;
          if (stim_addr < len_q - ADDR_WIDTH'(1)) begin
            stim_addr <= stim_addr + ADDR_WIDTH'(1);
          end
          if (cnt == '0) begin
            cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            state <= S_FLUSH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_FLUSH: begin
          mod_in <= MIDSCALE;
          mod_en <= 1'b1;
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          mod_en    <= 1'b0;
          mod_rstn  <= 1'b0;
          mod_in    <= MIDSCALE;
          stim_addr <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture bookkeeping: settle counter, FIFO pointers/occupancy, overflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dec_cnt  <= '0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dec_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (cic_ce && in_window && !settled) begin
        dec_cnt <= dec_cnt + DEC_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; out_data is masked while the FIFO
  // is empty, so stale or uninitialised entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= $unsigned(cic_out);
    end
  end

endmodule

// File: tb/tb_dsm_run_ctrl.sv
// Directed bench for dsm_run_ctrl: each run is driven from a per-cycle plan
// (offset 0 = the start cycle), outputs are logged per cycle and compared
// against hand-computed values afterwards.
module tb_dsm_run_ctrl;

  localparam int WIDTH      = 16;
  localparam int CIC_WIDTH  = 26;
  localparam int ADDR_WIDTH = 20;
  localparam int RST        = 5;
  localparam int FLUSH      = 128;
  localparam int SETTLE     = 4;
  localparam int MAXT       = 200;

  logic                        clk;
  logic                        rstn;
  logic                        start;
  logic [ADDR_WIDTH-1:0]       cfg_len;
  logic [ADDR_WIDTH-1:0]       stim_addr;
  logic [WIDTH-1:0]            stim_data;
  logic                        mod_rstn;
  logic                        mod_en;
  logic [WIDTH-1:0]            mod_in;
  logic signed [CIC_WIDTH-1:0] cic_out;
  logic                        cic_ce;
  logic [CIC_WIDTH-1:0]        out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;
  logic                        done;
  logic                        overflow;

  dsm_run_ctrl #(
    .WIDTH(WIDTH), .CIC_WIDTH(CIC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .RST_CYCLES(RST), .FLUSH_CYCLES(FLUSH), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len(cfg_len),
    .stim_addr(stim_addr), .stim_data(stim_data),
    .mod_rstn(mod_rstn), .mod_en(mod_en), .mod_in(mod_in),
    .cic_out(cic_out), .cic_ce(cic_ce),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read stimulus memory model.
  logic [WIDTH-1:0] mem [64];
  always @(posedge clk) stim_data <= mem[stim_addr[5:0]];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle plan and log, indexed by offset from the start cycle.
  bit                    p_start [MAXT];
  logic [ADDR_WIDTH-1:0] p_len   [MAXT];
  bit                    p_rst   [MAXT];
  bit                    p_ce    [MAXT];
  logic [CIC_WIDTH-1:0]  p_val   [MAXT];
  bit                    p_rdy   [MAXT];

  bit                    l_rstn  [MAXT];
  bit                    l_en    [MAXT];
  bit                    l_done  [MAXT];
  bit                    l_busy  [MAXT];
  bit                    l_ovf   [MAXT];
  bit                    l_valid [MAXT];
  logic [WIDTH-1:0]      l_in    [MAXT];
  logic [ADDR_WIDTH-1:0] l_addr  [MAXT];
  logic [CIC_WIDTH-1:0]  l_data  [MAXT];

  logic [CIC_WIDTH-1:0]  got_q [$];

  task automatic clear_plan();
    for (int i = 0; i < MAXT; i++) begin
      p_start[i] = 1'b0; p_len[i] = '0; p_rst[i] = 1'b0;
      p_ce[i] = 1'b0; p_val[i] = '0; p_rdy[i] = 1'b0;
    end
    got_q.delete();
  endtask

  // Pulse start with len at offset 0, then replay the plan for offsets 1..n-1.
  task automatic launch(input int len, input int n);
    @(posedge clk); #1;
    start   = 1'b1;
    cfg_len = ADDR_WIDTH'(len);
    for (int t = 1; t < n; t++) begin
      @(posedge clk); #1;
      start     = p_start[t];
      cfg_len   = p_start[t] ? p_len[t] : 20'h0BEEF;
      rstn      = !p_rst[t];
      cic_ce    = p_ce[t];
      cic_out   = p_val[t];
      out_ready = p_rdy[t];
      @(negedge clk);
      l_rstn[t] = mod_rstn; l_en[t] = mod_en; l_done[t] = done;
      l_busy[t] = busy; l_ovf[t] = overflow; l_valid[t] = out_valid;
      l_in[t] = mod_in; l_addr[t] = stim_addr; l_data[t] = out_data;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
    @(posedge clk); #1;
    start = 1'b0; cic_ce = 1'b0; out_ready = 1'b0; rstn = 1'b1;
  endtask

  // Summaries over the log for offsets 1..n-1.
  task automatic scan(input int n, input int mid_from,
                      output int rst_low, output int first_en, output int en_cnt,
                      output int done_at, output int done_cnt, output int mid_bad,
                      output int addr_nz);
    bit seen_high = 1'b0;
    rst_low = 0; first_en = -1; en_cnt = 0; done_at = -1; done_cnt = 0;
    mid_bad = 0; addr_nz = 0;
    for (int t = 1; t < n; t++) begin
      if (!seen_high && !l_rstn[t]) rst_low++;
      if (l_rstn[t]) seen_high = 1'b1;
      if (l_en[t]) begin
        en_cnt++;
        if (first_en < 0) first_en = t;
        if (t >= mid_from && l_in[t] != 16'h8000) mid_bad++;
      end
      if (l_done[t]) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (l_addr[t] != '0) addr_nz++;
    end
  endtask

  logic [WIDTH-1:0] exp_in [8];
  int rst_low, first_en, en_cnt, done_at, done_cnt, mid_bad, addr_nz;

  initial begin
    rstn = 1'b0; start = 1'b1; cfg_len = 20'd8;
    cic_ce = 1'b0; cic_out = '0; out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 16'h0000; mem[1] = 16'h7FFF; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
    mem[4] = 16'h1234; mem[5] = 16'h8001; mem[6] = 16'h7FFE; mem[7] = 16'h00FF;
    exp_in[0] = 16'h8000; exp_in[1] = 16'hFFFF; exp_in[2] = 16'h0000; exp_in[3] = 16'h7FFF;
    exp_in[4] = 16'h9234; exp_in[5] = 16'h0001; exp_in[6] = 16'hFFFE; exp_in[7] = 16'h80FF;

    // Reset held for 3 cycles with start high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mod_rstn", 32'(mod_rstn), 0);
    check("rst_mod_en", 32'(mod_en), 0);
    check("rst_mod_in", 32'(mod_in), 32'h8000);
    check("rst_stim_addr", 32'(stim_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    @(posedge clk); #1;
    rstn = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_no_accept", 32'(busy), 0);

    // Basic run, len=8, with an ignored start (len=3) while busy.
    clear_plan();
    p_start[4] = 1'b1; p_len[4] = 20'd3;
    launch(8, 147);
    scan(147, RST + 3 + 8, rst_low, first_en, en_cnt, done_at, done_cnt, mid_bad, addr_nz);
    check("basic_busy_s1", 32'(l_busy[1]), 1);
    check("basic_rstn_low", 32'(rst_low), RST);
    check("basic_first_en", 32'(first_en), RST + 3);
    for (int k = 0; k < 8; k++)
      check($sformatf("basic_mod_in_%0d", k), 32'(l_in[RST + 3 + k]), 32'(exp_in[k]));
    check("basic_addr_prime", 32'(l_addr[RST + 1]), 0);
    check("basic_addr_run0", 32'(l_addr[RST + 2]), 1);
    check("basic_addr_sat", 32'(l_addr[RST + 9]), 7);
    check("basic_en_cnt", 32'(en_cnt), 8 + FLUSH);
    check("basic_flush_mid", 32'(mid_bad), 0);
    check("basic_done_at", 32'(done_at), RST + 2 + 8 + FLUSH);
    check("basic_done_cnt", 32'(done_cnt), 1);
    check("basic_busy_after", 32'(l_busy[144]), 0);
    check("basic_rstn_after", 32'(l_rstn[144]), 0);

    // Settle discard: pulses 1..10 at offsets 8..17, plus pulses outside the window.
    clear_plan();
    for (int t = 0; t < MAXT; t++) p_rdy[t] = 1'b1;
    for (int t = 8; t <= 17; t++) begin p_ce[t] = 1'b1; p_val[t] = CIC_WIDTH'(t - 7); end
    p_ce[3] = 1'b1;   p_val[3] = 26'd99;
    p_ce[154] = 1'b1; p_val[154] = 26'd77;
    launch(16, 156);
    scan(156, 1000, rst_low, first_en, en_cnt, done_at, done_cnt, mid_bad, addr_nz);
    check("settle_count", 32'(got_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) check($sformatf("settle_val_%0d", i), 32'(got_q[i]), 32'(5 + i));
    check("settle_valid_pre", 32'(l_valid[12]), 0);
    check("settle_valid_lat", 32'(l_valid[13]), 1);
    check("settle_data_lat", 32'(l_data[13]), 5);
    check("settle_done_at", 32'(done_at), RST + 2 + 16 + FLUSH);

    // Overflow: 13 pulses with out_ready low, then a push onto a full FIFO with a pop.
    clear_plan();
    for (int t = 8; t <= 20; t++) begin p_ce[t] = 1'b1; p_val[t] = CIC_WIDTH'(t - 7); end
    p_ce[22] = 1'b1; p_val[22] = 26'd50; p_rdy[22] = 1'b1;
    launch(16, 153);
    check("ovf_before", 32'(l_ovf[16]), 0);
    check("ovf_full_valid", 32'(l_valid[16]), 1);
    check("ovf_set", 32'(l_ovf[17]), 1);
    check("ovf_head", 32'(l_data[21]), 5);
    check("ovf_pop_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("ovf_pop_val", 32'(got_q[0]), 5);
    check("ovf_head_after_pop", 32'(l_data[23]), 6);
    check("ovf_sticky", 32'(l_ovf[152]), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      if (out_valid) got_q.push_back(out_data);
    end
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("ovf_drain_count", 32'(got_q.size()), 4);
    for (int i = 1; i < 4; i++)
      if (i < got_q.size()) check($sformatf("ovf_drain_%0d", i), 32'(got_q[i]), 32'(5 + i));
    check("ovf_last_valid", 32'(out_valid), 1);
    check("ovf_last_data", 32'(out_data), 50);

    // Zero-length run; the leftover entry must be flushed by start.
    clear_plan();
    launch(0, 140);
    scan(140, 1, rst_low, first_en, en_cnt, done_at, done_cnt, mid_bad, addr_nz);
    check("zero_residue_flushed", 32'(l_valid[1]), 0);
    check("zero_ovf_cleared", 32'(l_ovf[1]), 0);
    check("zero_rstn_low", 32'(rst_low), RST);
    check("zero_first_en", 32'(first_en), RST + 3);
    check("zero_en_cnt", 32'(en_cnt), FLUSH);
    check("zero_mid", 32'(mid_bad), 0);
    check("zero_addr", 32'(addr_nz), 0);
    check("zero_done_at", 32'(done_at), RST + 2 + FLUSH);
    check("zero_done_cnt", 32'(done_cnt), 1);

    // Mid-run abort with rstn; a start while busy is ignored.
    clear_plan();
    for (int t = 7; t <= 11; t++) begin p_ce[t] = 1'b1; p_val[t] = CIC_WIDTH'(t - 6); end
    p_start[9] = 1'b1; p_len[9] = 20'd2;
    p_rst[13] = 1'b1;
    launch(16, 21);
    scan(21, 1000, rst_low, first_en, en_cnt, done_at, done_cnt, mid_bad, addr_nz);
    check("abort_pre_valid", 32'(l_valid[12]), 1);
    check("abort_pre_en", 32'(l_en[12]), 1);
    check("abort_pre_busy", 32'(l_busy[12]), 1);
    check("abort_busy", 32'(l_busy[14]), 0);
    check("abort_mod_rstn", 32'(l_rstn[14]), 0);
    check("abort_mod_in", 32'(l_in[14]), 32'h8000);
    check("abort_mod_en", 32'(l_en[14]), 0);
    check("abort_valid", 32'(l_valid[14]), 0);
    check("abort_addr", 32'(l_addr[14]), 0);
    check("abort_stays_idle", 32'(l_busy[20]), 0);
    check("abort_no_done", 32'(done_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
